// File: rtl/seq1101_fsm_trio.sv
// Overlapping 1-1-0-1 serial detector built three ways (Moore, behavioural Mealy,
// gate-level Mealy) with registered Mealy copies and a cross-check flag.
module seq1101_fsm_trio (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out_moore,
    output logic out_mealy,
    output logic sync_mealy,
    output logic out_gate,
    output logic sync_gate,
    output logic mismatch
);

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4
    } moore_t;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } mealy_t;

    moore_t moore_q, moore_d;
    mealy_t mealy_q, mealy_d;
    logic   mealy_out_d;
    logic   sync_mealy_q;
    logic   sync_gate_q;
    logic   q1_q, q0_q;
    logic   n1_d, n0_d;
    logic   gate_out_d;

    // ---------------- Moore FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            moore_q <= M0;
        end else begin
            moore_q <= moore_d;
        end
    end

    always_comb begin
        moore_d = M0;
        case (moore_q)
            M0:      moore_d = in ? M1 : M0;
            M1:      moore_d = in ? M2 : M0;
            M2:      moore_d = in ? M2 : M3;
            M3:      moore_d = in ? M4 : M0;
            M4:      moore_d = in ? M2 : M0;
            default: moore_d = M0;
        endcase
    end

    assign out_moore = (moore_q == M4);

    // ---------------- Behavioural Mealy FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mealy_q      <= S0;
            sync_mealy_q <= 1'b0;
        end else begin
            mealy_q      <= mealy_d;
            sync_mealy_q <= mealy_out_d;
        end
    end

    always_comb begin
        mealy_d     = S0;
        mealy_out_d = 1'b0;
        case (mealy_q)
            S0: mealy_d = in ? S1 : S0;
            S1: mealy_d = in ? S2 : S0;
            S2: mealy_d = in ? S2 : S3;
            S3: begin
                mealy_d     = in ? S1 : S0;
                mealy_out_d = in;
            end
            default: mealy_d = S0;
        endcase
    end

    assign out_mealy  = mealy_out_d;
    assign sync_mealy = sync_mealy_q;

    // ---------------- Gate-level Mealy FSM (Gray: S0=00 S1=01 S2=11 S3=10) ----------------
    assign n1_d       = q0_q & (q1_q | in);
    assign n0_d       = in;
    assign gate_out_d = q1_q & ~q0_q & in;

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_q        <= 1'b0;
            q0_q        <= 1'b0;
            sync_gate_q <= 1'b0;
        end else begin
            q1_q        <= n1_d;
            q0_q        <= n0_d;
            sync_gate_q <= gate_out_d;
        end
    end

    assign out_gate  = gate_out_d;
    assign sync_gate = sync_gate_q;

    // ---------------- Cross-check ----------------
    assign mismatch = (out_moore ^ sync_mealy) | (out_moore ^ sync_gate) | (out_mealy ^ out_gate);

endmodule

// File: tb/tb_seq1101_fsm_trio.sv
// Scoreboard bench for seq1101_fsm_trio: a bit-window reference model predicts every
// output each cycle; a monitor compares the DUT against the queued predictions.
module tb_seq1101_fsm_trio;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0;
    logic out_moore, out_mealy, sync_mealy, out_gate, sync_gate, mismatch;

    seq1101_fsm_trio dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .out_moore (out_moore),
        .out_mealy (out_mealy),
        .sync_mealy(sync_mealy),
        .out_gate  (out_gate),
        .sync_gate (sync_gate),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk;
        bit comb;
        bit regd;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int hits  = 0;

    // Reference model: the bits received since the last reset, kept as a window.
    bit [2:0] hist      = 3'b000;
    int       cnt       = 0;
    bit       reg_model = 1'b0;
    bit       inited    = 1'b0;

    task automatic check(input string name, input logic act, input logic expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic drive(input bit r, input bit b);
        exp_t e;
        @(negedge clk);
        rst = r;
        din = b;
        e.chk  = inited;
        e.comb = (cnt >= 3) && (hist == 3'b110) && b;
        e.regd = reg_model;
        exp_q.push_back(e);
        if (r) begin
            cnt       = 0;
            hist      = 3'b000;
            reg_model = 1'b0;
            inited    = 1'b1;
        end else begin
            hist      = {hist[1:0], b};
            cnt       = cnt + 1;
            reg_model = e.comb;
        end
    endtask

    task automatic stream(input bit [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b0, bits[i]);
    endtask

    // Monitor: samples mid-cycle, after inputs settle and before the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                check("out_mealy",  out_mealy,  e.comb);
                check("out_gate",   out_gate,   e.comb);
                check("out_moore",  out_moore,  e.regd);
                check("sync_mealy", sync_mealy, e.regd);
                check("sync_gate",  sync_gate,  e.regd);
                check("mismatch",   mismatch,   1'b0);
                if (out_moore === 1'b1) hits++;
            end
        end
    end

    task automatic expect_hits(input string name, input int h0, input int n);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        #6;
        tests++;
        if (hits - h0 != n) begin
            fails++;
            $display("FAIL %s: got %0d pulses expected %0d", name, hits - h0, n);
        end
    endtask

    initial begin
        int h0;
        bit [13:0] w;

        // Reset held for 10 cycles while in toggles
        for (int i = 0; i < 10; i++) drive(1'b1, i[0]);

        h0 = hits;
        stream(16'b11010, 5);
        expect_hits("single_1101", h0, 1);

        drive(1'b1, 1'b0);
        h0 = hits;
        stream(16'b1101101, 7);
        expect_hits("overlap_1101101", h0, 2);

        drive(1'b1, 1'b0);
        h0 = hits;
        stream(16'b111101, 6);
        expect_hits("run_111101", h0, 1);

        drive(1'b1, 1'b0);
        h0 = hits;
        stream(16'b1011001, 7);
        expect_hits("none_1011001", h0, 0);

        drive(1'b1, 1'b0);
        h0 = hits;
        stream(16'b110, 3);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        expect_hits("reset_mid_seq", h0, 0);

        // Words 0..500 step 7, 14 bits LSB-first
        for (int v = 0; v <= 500; v += 7) begin
            w = v[13:0];
            for (int i = 0; i < 14; i++) drive(1'b0, w[i]);
        end

        // Random stream with occasional resets
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1);
        end

        drive(1'b0, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #6;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
